// File: rtl/clock_enable_gen_if.sv
// Configuration, debug-control and enable-output bundle for clock_enable_gen.
// The master side programs divisors and drives ch0 debug; the slave side is the generator.
interface clock_enable_gen_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
);
  logic                    cfg_we;
  logic [2:0]              cfg_ch;
  logic [CNT_W-1:0]        cfg_div;
  logic [1:0]              mode;
  logic                    step_req;
  logic [NUM_CH-1:0]       ce;
  logic [NUM_CH-1:0]       tick;
  logic                    step_busy;
  logic [NUM_CH*CNT_W-1:0] div_rd;

  modport master (
    output cfg_we, cfg_ch, cfg_div, mode, step_req,
    input  ce, tick, step_busy, div_rd
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_div, mode, step_req,
    output ce, tick, step_busy, div_rd
  );
endinterface

// File: rtl/clock_enable_gen.sv
// Multi-channel programmable clock-enable generator with glitch-free divisor reload
// and HALT / single-STEP debug control on channel 0.
module clock_enable_gen #(
  parameter int                      NUM_CH   = 4,
  parameter int                      CNT_W    = 16,
  parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = {NUM_CH{CNT_W'(1)}}
) (
  input  logic              clock,
  input  logic              reset,
  clock_enable_gen_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_STEP = 2'd2
  } state_e;

  logic [CNT_W-1:0]  cnt_q     [NUM_CH];
  logic [CNT_W-1:0]  div_act_q [NUM_CH];
  logic [CNT_W-1:0]  div_shd_q [NUM_CH];
  logic [NUM_CH-1:0] pend_q;
  logic [NUM_CH-1:0] ce_q;
  logic [NUM_CH-1:0] tick_q;
  state_e            state_q;
  logic              busy_q;

  logic [CNT_W-1:0]  d_eff  [NUM_CH];
  logic [NUM_CH-1:0] run_en;
  logic [NUM_CH-1:0] wrap;
  logic [NUM_CH-1:0] we_hit;
  logic              halt_mode;

  // Both HALT (01) and STEP-arm (10) request a stopped ch0; 00 and 11 mean run.
  assign halt_mode = (bus.mode == 2'b01) || (bus.mode == 2'b10);

  // Per-channel effective divisor, wrap detection and write decode.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      d_eff[i]  = (div_act_q[i] == '0) ? CNT_W'(1) : div_act_q[i];
      run_en[i] = (i == 0) ? (state_q != ST_HALT) : 1'b1;
      wrap[i]   = run_en[i] && (cnt_q[i] == (d_eff[i] - CNT_W'(1)));
      we_hit[i] = bus.cfg_we && (bus.cfg_ch == 3'(i));
    end
  end

  // Counters, divisor shadow/active registers, outputs and the ch0 debug FSM.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]     <= '0;
        div_act_q[i] <= DIV_INIT[i*CNT_W +: CNT_W];
        div_shd_q[i] <= DIV_INIT[i*CNT_W +: CNT_W];
      end
      pend_q  <= '0;
      ce_q    <= '0;
      tick_q  <= '0;
      state_q <= ST_RUN;
      busy_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (we_hit[i]) begin
          div_shd_q[i] <= bus.cfg_div;
        end
        if (wrap[i]) begin
          cnt_q[i]  <= '0;
          ce_q[i]   <= 1'b1;
          tick_q[i] <= ~tick_q[i];
          pend_q[i] <= 1'b0;
          // A write landing on the wrap cycle is forwarded straight into the next period.
          if (we_hit[i]) begin
            div_act_q[i] <= bus.cfg_div;
          end else if (pend_q[i]) begin
            div_act_q[i] <= div_shd_q[i];
          end
        end else begin
          ce_q[i] <= 1'b0;
          if (run_en[i]) begin
            cnt_q[i] <= cnt_q[i] + CNT_W'(1);
          end
          if (we_hit[i]) begin
            pend_q[i] <= 1'b1;
          end
        end
      end

      case (state_q)
        ST_RUN: begin
          if (wrap[0] && halt_mode) begin
            state_q <= ST_HALT;
          end
        end
        ST_HALT: begin
          if (!halt_mode) begin
            state_q <= ST_RUN;
          end else if (bus.step_req) begin
            state_q <= ST_STEP;
            busy_q  <= 1'b1;
          end
        end
        ST_STEP: begin
          if (wrap[0]) begin
            state_q <= halt_mode ? ST_HALT : ST_RUN;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_RUN;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ce        = ce_q;
  assign bus.tick      = tick_q;
  assign bus.step_busy = busy_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_rd
    assign bus.div_rd[g*CNT_W +: CNT_W] = div_act_q[g];
  end

endmodule

// File: tb/tb_clock_enable_gen.sv
// Bench for clock_enable_gen: directed scenarios plus random traffic, all checked every
// cycle against an event-time reference model (each channel predicts its next pulse time).
module tb_clock_enable_gen;
  localparam int          NUM_CH   = 4;
  localparam int          CNT_W    = 16;
  localparam logic [63:0] DIV_INIT = {16'd7, 16'd3, 16'd50, 16'd1};

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  clock_enable_gen_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

  clock_enable_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DIV_INIT(DIV_INIT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: for every channel the absolute edge number of its next pulse.
  longint      cyc;
  longint      m_due  [NUM_CH];
  int unsigned m_act  [NUM_CH];
  int unsigned m_shd  [NUM_CH];
  bit          m_pend [NUM_CH];
  bit          m_ce   [NUM_CH];
  bit          m_tick [NUM_CH];
  int          m_st;                 // 0 running, 1 halted, 2 stepping
  logic [1:0]  cur_mode;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int unsigned deff(input int unsigned d);
    return (d == 0) ? 1 : d;
  endfunction

  task automatic model_reset();
    logic [63:0] init_v;
    init_v = DIV_INIT;
    cyc  = 0;
    m_st = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_act[i]  = init_v[i*16 +: 16];
      m_shd[i]  = m_act[i];
      m_pend[i] = 1'b0;
      m_ce[i]   = 1'b0;
      m_tick[i] = 1'b0;
      m_due[i]  = deff(m_act[i]);     // counting starts at edge 1
    end
  endtask

  task automatic model_edge(input bit we, input bit [2:0] ch, input logic [15:0] dv,
                            input bit [1:0] md, input bit st);
    bit halt_m;
    bit hit;
    cyc++;
    halt_m = (md == 2'd1) || (md == 2'd2);
    for (int i = 0; i < NUM_CH; i++) begin
      hit     = we && (int'(ch) == i);
      m_ce[i] = (m_due[i] == cyc);
      if (m_ce[i]) begin
        m_tick[i] = ~m_tick[i];
        if (hit) begin
          m_act[i] = dv; m_shd[i] = dv; m_pend[i] = 1'b0;
        end else if (m_pend[i]) begin
          m_act[i] = m_shd[i]; m_pend[i] = 1'b0;
        end
        m_due[i] = cyc + deff(m_act[i]);
      end else if (hit) begin
        m_shd[i] = dv; m_pend[i] = 1'b1;
      end
    end
    case (m_st)
      0: if (m_ce[0] && halt_m) begin m_st = 1; m_due[0] = -1; end
      1: begin
        if (!halt_m) begin m_st = 0; m_due[0] = cyc + deff(m_act[0]); end
        else if (st) begin m_st = 2; m_due[0] = cyc + deff(m_act[0]); end
      end
      2: if (m_ce[0]) begin
        m_st = halt_m ? 1 : 0;
        if (halt_m) m_due[0] = -1;
      end
      default: m_st = 0;
    endcase
  endtask

  task automatic compare_all();
    logic [63:0] e_ce, e_tick, e_div;
    e_ce = '0; e_tick = '0; e_div = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      e_ce[i]          = m_ce[i];
      e_tick[i]        = m_tick[i];
      e_div[i*16 +: 16] = 16'(m_act[i]);
    end
    check_eq("ce",        64'(bus.ce),        e_ce);
    check_eq("tick",      64'(bus.tick),      e_tick);
    check_eq("step_busy", 64'(bus.step_busy), 64'(m_st == 2));
    check_eq("div_rd",    64'(bus.div_rd),    e_div);
  endtask

  task automatic tick_cycle(input bit we, input bit [2:0] ch, input logic [15:0] dv,
                            input bit [1:0] md, input bit st);
    @(negedge clock);
    bus.cfg_we = we; bus.cfg_ch = ch; bus.cfg_div = dv; bus.mode = md; bus.step_req = st;
    @(posedge clock);
    if (reset) model_reset();
    else       model_edge(we, ch, dv, md, st);
    #1;
    compare_all();
  endtask

  task automatic idle(input int k);
    for (int j = 0; j < k; j++) tick_cycle(1'b0, 3'd0, 16'd0, cur_mode, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    // Busy inputs during reset must have no effect.
    tick_cycle(1'b1, 3'd0, 16'd9, 2'd1, 1'b1);
    tick_cycle(1'b1, 3'd2, 16'd4, 2'd2, 1'b1);
    reset = 1'b0;
  endtask

  task automatic wait_ce(input int ch, output int n);
    n = -1;
    for (int j = 1; j <= 200; j++) begin
      idle(1);
      if (bus.ce[ch]) begin n = j; break; end
    end
  endtask

  task automatic count_ce(input int ch, input int k, output int n);
    n = 0;
    for (int j = 0; j < k; j++) begin
      idle(1);
      if (bus.ce[ch]) n++;
    end
  endtask

  int n, pulses, first, busy_n;

  initial begin
    reset = 1'b1;
    bus.cfg_we = 1'b0; bus.cfg_ch = 3'd0; bus.cfg_div = 16'd0;
    bus.mode = 2'd0; bus.step_req = 1'b0;
    cur_mode = 2'd0;
    model_reset();
    do_reset();

    // ch1 reset divisor 50: first pulse on edge 50, then every 50.
    wait_ce(1, n);   check_eq("ce1_first", 64'(n), 64'd50);
    wait_ce(1, n);   check_eq("ce1_period", 64'(n), 64'd50);

    // ch0 divisor 1 and divisor 0 both pulse every cycle.
    count_ce(0, 10, n); check_eq("ce0_div1", 64'(n), 64'd10);
    tick_cycle(1'b1, 3'd0, 16'd0, cur_mode, 1'b0);
    idle(2);
    count_ce(0, 10, n); check_eq("ce0_div0", 64'(n), 64'd10);

    // ch2: program 10, then rewrite to 4 with cnt at 3; old period must finish.
    tick_cycle(1'b1, 3'd2, 16'd10, cur_mode, 1'b0);
    wait_ce(2, n);
    wait_ce(2, n);
    idle(3);
    tick_cycle(1'b1, 3'd2, 16'd4, cur_mode, 1'b0);
    wait_ce(2, n);   check_eq("ch2_old_period", 64'(n + 4), 64'd10);
    wait_ce(2, n);   check_eq("ch2_new_period", 64'(n), 64'd4);

    // ch0 divisor 5, then HALT: stops after the next wrap.
    tick_cycle(1'b1, 3'd0, 16'd5, cur_mode, 1'b0);
    idle(2);
    cur_mode = 2'd1;
    wait_ce(0, n);
    count_ce(0, 20, n); check_eq("halted_no_ce", 64'(n), 64'd0);

    // Single step with a second request while busy.
    tick_cycle(1'b0, 3'd0, 16'd0, cur_mode, 1'b1);
    pulses = 0; first = -1; busy_n = int'(bus.step_busy);
    for (int j = 1; j <= 11; j++) begin
      tick_cycle(1'b0, 3'd0, 16'd0, cur_mode, (j == 2));
      if (bus.step_busy) busy_n++;
      if (bus.ce[0]) begin pulses++; if (first < 0) first = j; end
    end
    check_eq("step_latency", 64'(first), 64'd5);
    check_eq("step_pulses", 64'(pulses), 64'd1);
    check_eq("step_busy_len", 64'(busy_n), 64'd5);

    // Back to RUN: resumes next cycle with period 5.
    cur_mode = 2'd0;
    wait_ce(0, n);   check_eq("resume_first", 64'(n), 64'd6);
    wait_ce(0, n);   check_eq("resume_period", 64'(n), 64'd5);

    // Reset in the middle of a step with a pending divisor write.
    cur_mode = 2'd1;
    wait_ce(0, n);
    idle(2);
    tick_cycle(1'b0, 3'd0, 16'd0, cur_mode, 1'b1);
    idle(1);
    tick_cycle(1'b1, 3'd0, 16'd9, cur_mode, 1'b0);
    check_eq("busy_before_rst", 64'(bus.step_busy), 64'd1);
    cur_mode = 2'd0;
    do_reset();
    check_eq("rst_div_rd", 64'(bus.div_rd), DIV_INIT);

    // Random traffic.
    for (int j = 0; j < 2500; j++) begin
      if ($urandom_range(0, 31) == 0) cur_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        tick_cycle(($urandom_range(0, 7) == 0), 3'($urandom_range(0, 7)),
                   16'($urandom_range(0, 12)), cur_mode, ($urandom_range(0, 7) == 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
